register_file_mp: RTL

Parametrised multi-port register file for the MIPS data path, successor to the single-write, two-read, 1-bit register file. It adds configurable data width, depth and read-port count, a second write port, optional write-to-read bypass and a per-register busy scoreboard. Multicycle and pipelined datapaths use the scoreboard for hazard detection. The block sits between decode (read addresses, reservations) and write-back (two write ports).

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_scoreboard.sv | 40 ++++
 rtl/register_file_mp.sv | 82 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and write-port priority for the multi-port register file
package regfile_pkg;

  parameter int RF_WIDTH = 32;
  parameter int RF_DEPTH = 32;
  parameter int RF_AW    = $clog2(RF_DEPTH);

  typedef logic [RF_AW-1:0]    rf_addr_t;
  typedef logic [RF_WIDTH-1:0] rf_data_t;

  localparam rf_addr_t ZERO_REG = '0;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_P0   = 2'd1,
    SEL_P1   = 2'd2
  } fwd_sel_t;

  // Port 1 is the younger producer, so it wins over port 0 on a shared address.
  function automatic fwd_sel_t fwd_sel(input logic hit0, input logic hit1);
    if (hit1) return SEL_P1;
    if (hit0) return SEL_P0;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with reserve/clear and stored-value lookups
module regfile_scoreboard #(
  parameter int DEPTH = 32,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [AW-1:0]      rsv_addr,
  input  logic               rsv_en,
  input  logic [AW-1:0]      clr0_addr,
  input  logic               clr0_en,
  input  logic [AW-1:0]      clr1_addr,
  input  logic               clr1_en,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD-1:0]   busy_out
);

  logic [DEPTH-1:0] busy;

  // A reservation outranks a same-cycle clear: it names a newer producer.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int r = 1; r < DEPTH; r++) begin
        if (rsv_en && rsv_addr == AW'(r))
          busy[r] <= 1'b1;
        else if ((clr0_en && clr0_addr == AW'(r)) || (clr1_en && clr1_addr == AW'(r)))
          busy[r] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_lookup
    assign busy_out[i] = busy[rd_addr[i*AW +: AW]];
  end

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - two-write, NREAD-read register file with optional bypass and busy scoreboard
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    RegRd,
  output logic [NREAD*WIDTH-1:0] dataOut,
  output logic [NREAD-1:0]       busyOut,
  input  logic [AW-1:0]          RegW0,
  input  logic [AW-1:0]          RegW1,
  input  logic [WIDTH-1:0]       dataIn0,
  input  logic [WIDTH-1:0]       dataIn1,
  input  logic                   RegWrite0,
  input  logic                   RegWrite1,
  input  logic [AW-1:0]          RegRsv,
  input  logic                   RsvEn
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Register 0 is never written outside reset, so it stays zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        case (fwd_sel(RegWrite0 && RegW0 == AW'(r), RegWrite1 && RegW1 == AW'(r)))
          SEL_P1:  mem[r] <= dataIn1;
          SEL_P0:  mem[r] <= dataIn0;
          default: ;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;

    assign addr = RegRd[i*AW +: AW];

    always_comb begin
      data = mem[addr];
      if (addr == '0) begin
        data = '0;
      end else if (BYPASS != 0) begin
        case (fwd_sel(RegWrite0 && RegW0 == addr, RegWrite1 && RegW1 == addr))
          SEL_P1:  data = dataIn1;
          SEL_P0:  data = dataIn0;
          default: ;
        endcase
      end
    end

    assign dataOut[i*WIDTH +: WIDTH] = data;
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .rsv_addr  (RegRsv),
    .rsv_en    (RsvEn),
    .clr0_addr (RegW0),
    .clr0_en   (RegWrite0),
    .clr1_addr (RegW1),
    .clr1_en   (RegWrite1),
    .rd_addr   (RegRd),
    .busy_out  (busyOut)
  );

endmodule
